glb_stream_writer: RTL and testbench
====================================

// Module: glb_stream_writer
// PURPOSE
//  Parametrised GLB-to-fabric stream source: streams cfg_tx_size words from a local word buffer to a ready/valid consumer.
//  Successor of the fixed 16-bit/32-word testbench writer: synthesizable, with runtime size, base address and buffer preload.
//  Sits between the GLB model and a tile input port in memory-core benches and sparse-stream harnesses.
// PARAMETERS
//  DATA_WIDTH  16    width of streamed word and buffer entry
//  DEPTH       1024  buffer entries (power of 2); ADDR_W = $clog2(DEPTH)
//  CNT_WIDTH   16    width of transfer-size and transfer counter
// PORTS
//  clk            in   1           clock; all logic on rising edge
//  rst            in   1           synchronous reset, active-high
//  flush          in   1           start strobe; rising edge (0->1) launches a stream
//  cfg_tx_size    in   CNT_WIDTH   words to send; sampled at start
//  cfg_base_addr  in   ADDR_W      first buffer address; sampled at start
//  mem_wr_en      in   1           buffer preload write enable
//  mem_wr_addr    in   ADDR_W      preload address
//  mem_wr_data    in   DATA_WIDTH  preload data
//  data           out  DATA_WIDTH  stream word, registered
//  valid          out  1           stream word valid
//  ready          in   1           consumer ready
//  done           out  1           stream complete, sticky
//  tx_count       out  CNT_WIDTH   beats accepted in current/last stream
//  stall_count    out  CNT_WIDTH   [GLB_WRITE_STALL_CNT_EN only] cycles with valid=1, ready=0
// BEHAVIOUR
//  Reset: data=0, valid=0, done=0, tx_count=0, stall_count=0, state=IDLE, flush_q=0; buffer contents not reset.
//  Start: start = flush & ~flush_q (flush_q = flush registered). Honoured in IDLE and DONE only; ignored in STREAM.
//  FSM IDLE/DONE --start, size>0--> STREAM: valid=1, data=mem[base], addr=base+1, tx_count=0, done=0.
//  FSM IDLE/DONE --start, size==0--> DONE: done=1, valid stays 0, tx_count=0.
//  Latency: flush first sampled high at edge N -> valid=1 in cycle after edge N.
//  Handshake: beat = valid & ready at an edge. valid/data held stable until beat; valid never drops without beat.
//  STREAM beat, tx_count+1 < size: data=mem[addr], addr=addr+1, tx_count+1; valid stays 1 (back-to-back 1 word/cycle).
//  STREAM beat, tx_count+1 == size: valid=0, done=1, tx_count=size, state=DONE (done visible cycle after last beat).
//  done sticky until next accepted start or rst. data holds last word after stream ends.
//  Address arithmetic mod DEPTH: wraps DEPTH-1 -> 0; cfg_tx_size > DEPTH legal, re-reads wrapped entries.
//  Preload: mem_wr_en writes buffer in IDLE/DONE; ignored in STREAM (no read/write hazard).
//  Preload and start same edge: write completes; stream's first word reads pre-write contents of that address.
//  rst mid-stream: aborts, all outputs to reset values at that edge; a new flush edge required to restart.
//  flush held high: one stream only; must return 0 before next start.
// CONFIGURATION
//  GLB_WRITE_STALL_CNT_EN defined: stall_count present; cleared at start, +1 each STREAM cycle valid&~ready, saturates at all-ones, holds in DONE.
//  Undefined: stall_count port and logic absent; all other behaviour identical.
// TESTING
//  Preload mem[0..31]=i+1, size=32, base=0, ready=1, flush 0->1 -> 32 consecutive beats 0x0001..0x0020, done=1 cycle after beat 32, tx_count=32.
//  Same, ready toggled 1,0,0,1,... -> data/valid stable through stalls, order unchanged; with _EN stall_count = number of ready=0 cycles in STREAM.
//  DEPTH=1024, base=1022, size=4 -> words mem[1022],mem[1023],mem[0],mem[1]; done=1.
//  size=0, flush edge -> valid never rises, done=1 cycle after start, tx_count=0.
//  rst pulse after beat 10 of 32 -> valid=0, done=0, tx_count=0 next cycle; new flush edge restreams from base, 32 beats.
//  Second flush edge mid-stream and mem_wr_en mid-stream -> both ignored; stream data matches pre-start buffer contents.

Source files
------------

// File: rtl/glb_stream_writer.sv
// glb_stream_writer: streams cfg_tx_size words from a local preloadable word
// buffer to a ready/valid consumer, starting at cfg_base_addr.
// Optional feature macro: GLB_WRITE_STALL_CNT_EN adds the stall_count port
// (cycles with valid=1 and ready=0 during the current/last stream).
module glb_stream_writer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 1024,
    parameter  int CNT_WIDTH  = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [CNT_WIDTH-1:0]  cfg_tx_size,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic                  mem_wr_en,
    input  logic [ADDR_W-1:0]     mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tx_count
`ifdef GLB_WRITE_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]    ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r,   state_nxt_s;
    logic                  flush_q_r;
    logic                  start_s;
    logic                  valid_r,   valid_nxt_s;
    logic                  done_r,    done_nxt_s;
    logic [DATA_WIDTH-1:0] data_r,    data_nxt_s;
    logic [ADDR_W-1:0]     addr_r,    addr_nxt_s;
    logic [CNT_WIDTH-1:0]  tx_cnt_r,  tx_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]  tx_size_r, tx_size_nxt_s;
    logic [CNT_WIDTH-1:0]  tx_inc_s;
    logic                  mem_we_s;
`ifdef GLB_WRITE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0]  stall_r,   stall_nxt_s;
`endif

    assign start_s  = flush & ~flush_q_r;
    assign tx_inc_s = tx_cnt_r + CNT_ONE;
    // Buffer writes are blocked while streaming so reads never see a hazard.
    assign mem_we_s = mem_wr_en & (state_r != ST_STREAM);

    // Preload port: write the word buffer outside of an active stream.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wr_addr] <= mem_wr_data;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            flush_q_r <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            data_r    <= {DATA_WIDTH{1'b0}};
            addr_r    <= ADDR_ZERO;
            tx_cnt_r  <= CNT_ZERO;
            tx_size_r <= CNT_ZERO;
`ifdef GLB_WRITE_STALL_CNT_EN
            stall_r   <= CNT_ZERO;
`endif
        end else begin
            state_r   <= state_nxt_s;
            flush_q_r <= flush;
            valid_r   <= valid_nxt_s;
            done_r    <= done_nxt_s;
            data_r    <= data_nxt_s;
            addr_r    <= addr_nxt_s;
            tx_cnt_r  <= tx_cnt_nxt_s;
            tx_size_r <= tx_size_nxt_s;
`ifdef GLB_WRITE_STALL_CNT_EN
            stall_r   <= stall_nxt_s;
`endif
        end
    end

    // Next-state and datapath logic: start, beat advance, completion.
    always_comb begin
        state_nxt_s   = state_r;
        valid_nxt_s   = valid_r;
        done_nxt_s    = done_r;
        data_nxt_s    = data_r;
        addr_nxt_s    = addr_r;
        tx_cnt_nxt_s  = tx_cnt_r;
        tx_size_nxt_s = tx_size_r;
`ifdef GLB_WRITE_STALL_CNT_EN
        stall_nxt_s   = stall_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    tx_size_nxt_s = cfg_tx_size;
                    tx_cnt_nxt_s  = CNT_ZERO;
`ifdef GLB_WRITE_STALL_CNT_EN
                    stall_nxt_s   = CNT_ZERO;
`endif
                    if (cfg_tx_size != CNT_ZERO) begin
                        state_nxt_s = ST_STREAM;
                        valid_nxt_s = 1'b1;
                        done_nxt_s  = 1'b0;
                        // Read sees the pre-write contents if a preload hits the same edge.
                        data_nxt_s  = mem_r[cfg_base_addr];
                        addr_nxt_s  = cfg_base_addr + ADDR_ONE;
                    end else begin
                        state_nxt_s = ST_DONE;
                        valid_nxt_s = 1'b0;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_STREAM: begin
                if (valid_r && ready) begin
                    if (tx_inc_s == tx_size_r) begin
                        state_nxt_s  = ST_DONE;
                        valid_nxt_s  = 1'b0;
                        done_nxt_s   = 1'b1;
                        tx_cnt_nxt_s = tx_size_r;
                    end else begin
                        // Address wraps naturally modulo DEPTH.
                        data_nxt_s   = mem_r[addr_r];
                        addr_nxt_s   = addr_r + ADDR_ONE;
                        tx_cnt_nxt_s = tx_inc_s;
                    end
                end else begin
`ifdef GLB_WRITE_STALL_CNT_EN
                    if (valid_r && (stall_r != {CNT_WIDTH{1'b1}})) begin
                        stall_nxt_s = stall_r + CNT_ONE;
                    end else begin
                        stall_nxt_s = stall_r;
                    end
`else
                    state_nxt_s = ST_STREAM;
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    assign data     = data_r;
    assign valid    = valid_r;
    assign done     = done_r;
    assign tx_count = tx_cnt_r;
`ifdef GLB_WRITE_STALL_CNT_EN
    assign stall_count = stall_r;
`endif

endmodule

// File: tb/tb_glb_stream_writer.sv
// Directed testbench for glb_stream_writer (DATA_WIDTH=16, DEPTH=1024).
module tb_glb_stream_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] cfg_tx_size;
    logic [9:0]  cfg_base_addr;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        done;
    logic [15:0] tx_count;
`ifdef GLB_WRITE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_pass  = 0;
    int n_check = 0;

    glb_stream_writer #(.DATA_WIDTH(16), .DEPTH(1024), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .cfg_tx_size   (cfg_tx_size),
        .cfg_base_addr (cfg_base_addr),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .done          (done),
        .tx_count      (tx_count)
`ifdef GLB_WRITE_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int k;
        int cyc;
        int stalls;

        rst = 1'b1; flush = 1'b0; cfg_tx_size = 16'd0; cfg_base_addr = 10'd0;
        mem_wr_en = 1'b0; mem_wr_addr = 10'd0; mem_wr_data = 16'd0; ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_txcnt", {16'd0, tx_count}, 32'd0);

        // Preload mem[i] = i+1 for i = 0..31
        for (int i = 0; i < 32; i++) begin
            mem_wr_en = 1'b1; mem_wr_addr = 10'(i); mem_wr_data = 16'(i + 1);
            tick();
        end
        mem_wr_en = 1'b0;

        // 1: back-to-back stream of 32 words, flush held high throughout
        cfg_tx_size = 16'd32; cfg_base_addr = 10'd0; ready = 1'b1; flush = 1'b1;
        tick();
        chk("s1_done_low", {31'd0, done}, 32'd0);
        for (k = 1; k <= 32; k++) begin
            chk("s1_valid", {31'd0, valid}, 32'd1);
            chk("s1_data", {16'd0, data}, 32'(k));
            tick();
        end
        chk("s1_end_valid", {31'd0, valid}, 32'd0);
        chk("s1_end_done", {31'd0, done}, 32'd1);
        chk("s1_end_txcnt", {16'd0, tx_count}, 32'd32);
        chk("s1_end_data", {16'd0, data}, 32'd32);
        tick(); tick();
        chk("s1_hold_no_restart", {31'd0, valid}, 32'd0);
        chk("s1_done_sticky", {31'd0, done}, 32'd1);
        flush = 1'b0;
        tick();

        // 2: ready pattern 1,0,0,1 repeating; stalls must not disturb order
        flush = 1'b1;
        tick();
        flush = 1'b0;
        k = 1; stalls = 0; cyc = 0;
        while (k <= 32 && cyc < 200) begin
            chk("s2_valid", {31'd0, valid}, 32'd1);
            chk("s2_data", {16'd0, data}, 32'(k));
            ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (ready) k++;
            else stalls++;
            cyc++;
            tick();
        end
        ready = 1'b1;
        chk("s2_beats", 32'(k), 32'd33);
        chk("s2_done", {31'd0, done}, 32'd1);
        chk("s2_valid_low", {31'd0, valid}, 32'd0);
        chk("s2_txcnt", {16'd0, tx_count}, 32'd32);
`ifdef GLB_WRITE_STALL_CNT_EN
        chk("s2_stall_cnt", {16'd0, stall_count}, 32'(stalls));
`endif

        // 3: address wrap 1022,1023,0,1
        mem_wr_en = 1'b1; mem_wr_addr = 10'd1022; mem_wr_data = 16'hAA01; tick();
        mem_wr_addr = 10'd1023; mem_wr_data = 16'hAA02; tick();
        mem_wr_en = 1'b0;
        cfg_tx_size = 16'd4; cfg_base_addr = 10'd1022; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s3_w0", {16'd0, data}, 32'h0000AA01); tick();
        chk("s3_w1", {16'd0, data}, 32'h0000AA02); tick();
        chk("s3_w2", {16'd0, data}, 32'h00000001); tick();
        chk("s3_w3", {16'd0, data}, 32'h00000002); tick();
        chk("s3_done", {31'd0, done}, 32'd1);
        chk("s3_txcnt", {16'd0, tx_count}, 32'd4);

        // 4: size 0 after reset -> done without valid
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("s4_pre_done", {31'd0, done}, 32'd0);
        cfg_tx_size = 16'd0; cfg_base_addr = 10'd0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s4_valid", {31'd0, valid}, 32'd0);
        chk("s4_done", {31'd0, done}, 32'd1);
        chk("s4_txcnt", {16'd0, tx_count}, 32'd0);
        tick(); tick();
        chk("s4_valid_later", {31'd0, valid}, 32'd0);

        // 5: reset after 10 beats, then restream all 32
        cfg_tx_size = 16'd32; cfg_base_addr = 10'd0; flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("s5_txcnt10", {16'd0, tx_count}, 32'd10);
        chk("s5_data11", {16'd0, data}, 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_rst_valid", {31'd0, valid}, 32'd0);
        chk("s5_rst_done", {31'd0, done}, 32'd0);
        chk("s5_rst_txcnt", {16'd0, tx_count}, 32'd0);
        chk("s5_rst_data", {16'd0, data}, 32'd0);
        tick();
        chk("s5_no_restart", {31'd0, valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (k = 1; k <= 32; k++) begin
            chk("s5_data", {15'd0, valid, data}, 32'(32'h10000 + k));
            tick();
        end
        chk("s5_done", {31'd0, done}, 32'd1);
        chk("s5_txcnt", {16'd0, tx_count}, 32'd32);

        // 6: second flush edge and preload mid-stream are ignored
        flush = 1'b1;
        tick();
        for (k = 1; k <= 32; k++) begin
            chk("s6_data", {15'd0, valid, data}, 32'(32'h10000 + k));
            flush = (k != 5);
            mem_wr_en = (k == 8);
            mem_wr_addr = 10'd20; mem_wr_data = 16'hDEAD;
            tick();
        end
        flush = 1'b0; mem_wr_en = 1'b0;
        chk("s6_done", {31'd0, done}, 32'd1);
        chk("s6_valid", {31'd0, valid}, 32'd0);
        chk("s6_txcnt", {16'd0, tx_count}, 32'd32);
        tick();

        // 7: preload and start on the same edge -> first word is pre-write value
        cfg_tx_size = 16'd1; cfg_base_addr = 10'd20; flush = 1'b1;
        mem_wr_en = 1'b1; mem_wr_addr = 10'd20; mem_wr_data = 16'hBEEF;
        tick();
        flush = 1'b0; mem_wr_en = 1'b0;
        chk("s7_prewrite", {15'd0, valid, data}, 32'h00010015);
        tick();
        chk("s7_done", {31'd0, done}, 32'd1);
        chk("s7_txcnt", {16'd0, tx_count}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s7_postwrite", {15'd0, valid, data}, 32'h0001BEEF);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
